// File: rtl/mem_access_unit.sv
// Load/store access unit: byte/half/word alignment, req/ack memory bus, extended load result.
// Optional MEM_TIMEOUT_EN adds a bus_ack timeout that completes the access with bus_err.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        start,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_DONE = 2'd2} state_t;

  if ((TIMEOUT_CYCLES < 32'd1) || (TIMEOUT_CYCLES > 32'd65535)) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_t      state_q, state_d;
  logic        busy_q, busy_d, done_q, done_d, addr_err_q, addr_err_d;
  logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [31:0] rdata_q, rdata_d, bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [1:0]  size_q, size_d, lane_q, lane_d;
  logic        sign_ext_q, sign_ext_d;
  logic        legal_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
`ifdef MEM_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
  logic [15:0] tmo_q, tmo_d;
  logic        bus_err_q, bus_err_d;
`endif

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic [1:0] lane,
                                               input logic sext, input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (sz)
      2'b00:   res = {{24{sext & sh[7]}}, sh[7:0]};
      2'b01:   res = {{16{sext & sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  always_comb begin
    legal_s = 1'b0;
    be_s    = 4'b0000;
    wdata_s = wdata;
    case (size)
      2'b00: begin
        legal_s = 1'b1;
        be_s    = 4'b0001 << addr[1:0];
        wdata_s = {4{wdata[7:0]}};
      end
      2'b01: begin
        legal_s = ~addr[0];
        be_s    = 4'b0011 << addr[1:0];
        wdata_s = {2{wdata[15:0]}};
      end
      2'b10: begin
        legal_s = (addr[1:0] == 2'b00);
        be_s    = 4'b1111;
      end
      default: legal_s = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    addr_err_d  = 1'b0;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    rdata_d     = rdata_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    size_d      = size_q;
    lane_d      = lane_q;
    sign_ext_d  = sign_ext_q;
`ifdef MEM_TIMEOUT_EN
    tmo_d       = tmo_q;
    bus_err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (legal_s) begin
            state_d     = ST_REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = be_s;
            bus_wdata_d = wdata_s;
            size_d      = size;
            lane_d      = addr[1:0];
            sign_ext_d  = sign_ext;
`ifdef MEM_TIMEOUT_EN
            tmo_d       = 16'd0;
`endif
          end else begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            addr_err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_ack) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            rdata_d = load_extract(size_q, lane_q, sign_ext_q, bus_rdata);
          end else begin
            rdata_d = rdata_q;
          end
        end
`ifdef MEM_TIMEOUT_EN
        // An ack in the limit cycle takes the branch above and completes normally.
        else if (tmo_q == TMO_LAST) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
          bus_req_d = 1'b0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`else
        else begin
          state_d = ST_REQ;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      rdata_q     <= 32'd0;
      bus_addr_q  <= 32'd0;
      bus_be_q    <= 4'd0;
      bus_wdata_q <= 32'd0;
      size_q      <= 2'd0;
      lane_q      <= 2'd0;
      sign_ext_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_q       <= 16'd0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      addr_err_q  <= addr_err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      rdata_q     <= rdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      sign_ext_q  <= sign_ext_d;
`ifdef MEM_TIMEOUT_EN
      tmo_q       <= tmo_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign addr_err  = addr_err_q;
  assign rdata     = rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
`ifdef MEM_TIMEOUT_EN
  assign bus_err   = bus_err_q;
`else
  assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expectations, monitor pops on done/bus_req.
// With MEM_TIMEOUT_EN defined, timeout cases run with TIMEOUT_CYCLES=4.
module tb_mem_access_unit;

  localparam int TMO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam int LONG_DLY = 3;
`else
  localparam int LONG_DLY = 4;
`endif

  bit          CLK = 1'b0;
  logic        RST_n, start, mem_write, sign_ext, bus_ack;
  logic [1:0]  size;
  logic [31:0] addr, wdata, bus_rdata;
  logic        busy, done, addr_err, bus_err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  typedef struct { logic aerr; logic berr; logic upd; logic [31:0] rdata; int done_cyc; } resp_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  bit    rst_applied = 1'b0;
  bit    tb_end = 1'b0;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST_n(RST_n), .start(start), .mem_write(mem_write), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .addr_err(addr_err), .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    rst_applied <= !RST_n;
  end

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] cur_rdata = 32'd0;
  bit          req_prev = 1'b0;
  bus_t        held;
  resp_t       r;

  function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  always @(negedge CLK) begin
    if (cyc > 20000) begin
      $display("FAIL watchdog cycles=%0d limit=20000", cyc);
      $fatal(1, "watchdog expired");
    end
    if (cyc == 0) begin
      req_prev = 1'b0;
    end else if (tb_end) begin
      chk("resp_queue_drained", 128'(resp_q.size()), 128'd0);
      chk("bus_queue_drained", 128'(bus_q.size()), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else if (rst_applied) begin
      chk("reset_outputs", {busy, done, addr_err, bus_err, bus_req, bus_we,
                            rdata, bus_addr, bus_be, bus_wdata}, 128'd0);
      resp_q.delete();
      bus_q.delete();
      cur_rdata = 32'd0;
      req_prev  = 1'b0;
    end else begin
      if (bus_req) begin
        if (!req_prev) begin
          if (bus_q.size() == 0) chk("unexpected_bus_req", 128'd1, 128'd0);
          else held = bus_q.pop_front();
        end
        chk("bus_fields", {bus_we, bus_addr, bus_be, bus_wdata},
                          {held.we, held.addr, held.be, held.wdata});
      end
      req_prev = bus_req;
      if (done) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_done", 128'd1, 128'd0);
        end else begin
          r = resp_q.pop_front();
          chk("done_cycle", 128'(cyc), 128'(r.done_cyc));
          chk("addr_err", 128'(addr_err), 128'(r.aerr));
          chk("bus_err", 128'(bus_err), 128'(r.berr));
          chk("busy_req_at_done", {busy, bus_req}, 128'b10);
          if (r.upd) cur_rdata = r.rdata;
        end
      end else begin
        chk("no_err_pulse", {addr_err, bus_err}, 128'd0);
      end
      chk("rdata", 128'(rdata), 128'(cur_rdata));
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_txn(input logic we, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int dly, input bit noack, input bit repulse);
    int nb, lane;
    logic legal;
    logic [63:0] v;
    resp_t e;
    bus_t b;
    nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lane  = int'(a % 32'd4);
    legal = (sz != 2'd3) && ((a % nb) == 0);
    b.we   = we;
    b.addr = a & 32'hFFFF_FFFC;
    b.be   = 4'(((1 << nb) - 1) << lane);
    for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
    v = (64'(rd) >> (8 * lane)) & ((64'd1 << (8 * nb)) - 64'd1);
    if (sx && nb < 4 && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
    e.aerr  = !legal;
    e.berr  = legal && noack;
    e.upd   = legal && !we && !noack;
    e.rdata = v[31:0];
    e.done_cyc = !legal ? cyc + 1 : (noack ? cyc + 1 + TMO : cyc + 2 + dly);
    resp_q.push_back(e);
    if (legal) bus_q.push_back(b);
    start = 1'b1; mem_write = we; size = sz; sign_ext = sx; addr = a; wdata = wd;
    tick();
    start = 1'b0; mem_write = $urandom; size = 2'($urandom); sign_ext = $urandom;
    addr = $urandom; wdata = $urandom;
    if (legal) begin
      if (noack) begin
        repeat (TMO) begin
          start = repulse;
          tick();
        end
        start = 1'b0;
      end else begin
        repeat (dly) begin
          start = repulse;
          tick();
        end
        start = 1'b0;
        bus_ack = 1'b1; bus_rdata = rd;
        tick();
        bus_ack = $urandom; bus_rdata = $urandom;
        start = repulse;
      end
    end
    tick();
    start = 1'b0; bus_ack = 1'b0;
  endtask

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    RST_n = 1'b0; start = 1'b0; mem_write = 1'b0; size = 2'd0; sign_ext = 1'b0;
    addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (3) tick();
    RST_n = 1'b1;
    tick();
    do_txn(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h80FF_0000, 0, 1'b0, 1'b0);
    do_txn(1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 32'h9234_5678, 0, 1'b0, 1'b0);
    do_txn(1'b1, 2'b00, 1'b0, 32'h31, 32'h1234_56AB, 32'h0, 1, 1'b0, 1'b0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    do_txn(1'b0, 2'b11, 1'b1, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    do_txn(1'b0, 2'b01, 1'b1, 32'h402, 32'h0, 32'hA5C3_1E7F, LONG_DLY, 1'b0, 1'b1);
`ifdef MEM_TIMEOUT_EN
    do_txn(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, 32'h1111_2222, 0, 1'b1, 1'b0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h804, 32'h0, 32'h3333_4444, TMO - 1, 1'b0, 1'b0);
`endif
    for (int n = 0; n < 80; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ((sz == 2'd0) ? 32'hFFFF_FFFF :
                                              (sz == 2'd1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
      do_txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
             $urandom_range(0, 3), 1'b0, 1'($urandom));
    end
    // Reset in the third REQ cycle, then a late ack that must be ignored.
    bus_q.push_back('{we: 1'b0, addr: 32'h40, be: 4'hF, wdata: 32'h0});
    start = 1'b1; mem_write = 1'b0; size = 2'b10; addr = 32'h40; wdata = 32'h0;
    tick();
    start = 1'b0;
    tick();
    tick();
    RST_n = 1'b0;
    tick();
    RST_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_ack = 1'b0;
    repeat (3) tick();
    do_txn(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 32'h5A00_0000, 0, 1'b0, 1'b0);
    repeat (2) tick();
    tb_end = 1'b1;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store access unit sitting directly upstream of the memory data register in the MIPS datapath. Accepts one load or store per request from the control unit, performs byte/halfword/word alignment, drives a request/acknowledge memory bus, and delivers the aligned, sign- or zero-extended load word on `rdata`, which feeds the memory data register input. Misaligned accesses are trapped without touching the bus.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles waiting for `bus_ack` (used only with `MEM_TIMEOUT_EN`); range 1..65535.
- `CLK`  in  1  clock, all state updates on rising edge.
- `RST_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request pulse; accepted only when `busy`=0.
- `mem_write`  in  1  1=store, 0=load; sampled with `start`.
- `size`  in  2  00=byte, 01=half, 10=word, 11=illegal; sampled with `start`.
- `sign_ext`  in  1  loads only: 1=LB/LH sign-extend, 0=LBU/LHU zero-extend.
- `addr`  in  32  byte address; sampled with `start`.
- `wdata`  in  32  store data (rt); sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  aligned/extended load result; updates only on a successful load; held otherwise.
- `addr_err`  out  1  pulses with `done` on misaligned/illegal access.
- `bus_err`  out  1  pulses with `done` on timeout; constant 0 without `MEM_TIMEOUT_EN`.
- `bus_req`  out  1  bus request, held until ack.
- `bus_we`  out  1  1=write.
- `bus_addr`  out  32  `{addr[31:2],2'b00}`.
- `bus_be`  out  4  byte enables (bit i = byte lane i).
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_ack`  in  1  memory completion; sampled only in REQ.
- `bus_rdata`  in  32  read word, valid when `bus_ack`=1.

## Operation
- Little-endian; lane = `addr[1:0]`.
- FSM states: IDLE, REQ, DONE. IDLE + `start`: latch request; if legal -> REQ, else -> DONE with error flag. REQ + `bus_ack` -> DONE. DONE -> IDLE unconditionally.
- Legal: byte any address; half `addr[0]`=0; word `addr[1:0]`=0; `size`=11 always illegal.
- `bus_be`: byte `4'b0001<<addr[1:0]`; half `4'b0011<<addr[1:0]`; word `4'b1111`. Loads drive the same enables.
- `bus_wdata`: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word `wdata`.
- Load: select lane(s) from `bus_rdata`, extend per `sign_ext` to 32 bits (word ignores `sign_ext`); register into `rdata` on the ack edge.
- Stores, errors and timeouts leave `rdata` unchanged.
- `start` while `busy`=1 ignored; `bus_ack` outside REQ ignored.

## Timing
- Reset (edge with `RST_n`=0): state IDLE; `busy`, `done`, `addr_err`, `bus_err`, `bus_req`, `bus_we` = 0; `rdata`, `bus_addr`, `bus_be`, `bus_wdata` = 0. Reset mid-REQ drops `bus_req` at that edge; a later ack is ignored.
- Cycle 0 `start`; cycle 1 `bus_req`=1 with all bus fields stable; ack sampled at end of cycle k≥1; `done` (and valid `rdata`) in cycle k+1; `busy`=0 in cycle k+2. Minimum load/store latency start->done = 2 cycles.
- Error path: `start` cycle 0 -> `done`+`addr_err` cycle 1; `bus_req` never asserted.
- Bus fields held constant while `bus_req`=1; `bus_req` low in DONE.
- Back-to-back: next `start` accepted in the cycle after `done`.

## Configuration
- `MEM_TIMEOUT_EN` defined: a counter clears on REQ entry and increments each REQ cycle without ack; when it reaches `TIMEOUT_CYCLES` without ack, next edge -> DONE with `bus_err`=1, `bus_req` dropped. Ack in the limit cycle wins (normal completion, `bus_err`=0).
- Not defined: no counter; REQ waits indefinitely; `bus_err` tied 0.

## Test plan
- LB `addr`=0x1003, `sign_ext`=1, `bus_rdata`=0x80FF_0000, ack cycle 1 -> `bus_be`=1000, `rdata`=0xFFFF_FF80, `done` cycle 2.
- LHU `addr`=0x2002, `bus_rdata`=0x9234_5678 -> `bus_be`=1100, `rdata`=0x0000_9234.
- SB `addr`=0x31, `wdata`=0x1234_56AB -> `bus_we`=1, `bus_be`=0010, `bus_wdata`=0xABAB_ABAB, `rdata` unchanged.
- LW `addr`=0x6 -> `done`+`addr_err` 1 cycle after start, `bus_req` stays 0; `size`=11 same.
- Ack delayed 5 cycles with `start` re-pulsed while busy -> single transaction, `done` 6 cycles after request; reset in cycle 3 of a REQ -> all outputs 0 next cycle, late ack ignored.
- With `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no ack -> `bus_err`+`done` after limit, `rdata` unchanged; ack in limit cycle -> normal completion.
